// File: rtl/tod_counter_if.sv
// Control, load and time-display signals of tod_counter; the master side drives
// tick/run/mode/load, the slave side (the counter) returns the current time.
interface tod_counter_if;
   logic       tick;
   logic       run;
   logic       mode_12h;
   logic       load;
   logic [7:0] load_hr;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       load_pm;
   logic [7:0] hr;
   logic [7:0] min;
   logic [7:0] sec;
   logic       pm;
   logic       min_tick;
   logic       hr_tick;
   logic       day_tick;
   logic       load_err;

   modport master (
      output tick, run, mode_12h, load, load_hr, load_min, load_sec, load_pm,
      input  hr, min, sec, pm, min_tick, hr_tick, day_tick, load_err
   );

   modport slave (
      input  tick, run, mode_12h, load, load_hr, load_min, load_sec, load_pm,
      output hr, min, sec, pm, min_tick, hr_tick, day_tick, load_err
   );
endinterface

// File: rtl/tod_counter.sv
// BCD time-of-day counter (24-hour internal, 12/24-hour display and load) with prescaler.
// Optional load validation is enabled by defining TOD_LOAD_CHECK_EN.
module tod_counter #(
   parameter int         DIV    = 1,
   parameter logic [7:0] RST_HR = 8'h00
) (
   input logic          clk,
   input logic          reset,
   tod_counter_if.slave bus
);

   localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

   function automatic logic [7:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
      return ({4'd0, t} * 8'd10) + {4'd0, u};
   endfunction

   function automatic logic [7:0] bin_to_bcd(input logic [7:0] b);
      logic [7:0] r;
      logic [3:0] t;
      if (b >= 8'd20) begin
         t = 4'd2;
         r = b - 8'd20;
      end else if (b >= 8'd10) begin
         t = 4'd1;
         r = b - 8'd10;
      end else begin
         t = 4'd0;
         r = b;
      end
      return {t, r[3:0]};
   endfunction

   // 12-hour inputs are folded onto the internal 0..23 hour
   function automatic logic [7:0] load_hour(input logic [7:0] hb, input logic m12, input logic p);
      logic [7:0] r;
      if (!m12) begin
         r = hb;
      end else if (hb == 8'd12) begin
         r = p ? 8'd12 : 8'd0;
      end else if (p) begin
         r = hb + 8'd12;
      end else begin
         r = hb;
      end
      return r;
   endfunction

   function automatic logic [7:0] display_hour(input logic [7:0] hb, input logic m12);
      logic [7:0] r;
      if (!m12) begin
         r = hb;
      end else if (hb == 8'd0) begin
         r = 8'd12;
      end else if (hb >= 8'd13) begin
         r = hb - 8'd12;
      end else begin
         r = hb;
      end
      return r;
   endfunction

`ifdef TOD_LOAD_CHECK_EN
   function automatic logic load_ok(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s, input logic m12);
      logic       ok;
      logic [7:0] hb;
      hb = bcd_to_bin(h[7:4], h[3:0]);
      ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) &&
           (s[3:0] <= 4'd9) && (m[7:4] <= 4'd5) && (s[7:4] <= 4'd5);
      if (m12) begin
         ok = ok && (hb != 8'd0) && (hb <= 8'd12);
      end else begin
         ok = ok && (hb <= 8'd23);
      end
      return ok;
   endfunction
`endif

   logic [3:0]  hr_t_r, hr_u_r, min_t_r, min_u_r, sec_t_r, sec_u_r;
   logic [15:0] presc_r;
   logic        min_tick_r, hr_tick_r, day_tick_r, load_err_r;

   logic [3:0]  adv_hr_t_s, adv_hr_u_s, adv_min_t_s, adv_min_u_s, adv_sec_t_s, adv_sec_u_s;
   logic        sec_wrap_s, min_wrap_s, hr_wrap_s;
   logic [7:0]  ld_hr_s;
   logic        load_ok_s;
   logic [7:0]  cur_hr_bin_s;

   // One-second advance of the stored time with carry and wrap detection
   always_comb begin
      adv_sec_t_s = sec_t_r;
      adv_sec_u_s = sec_u_r;
      adv_min_t_s = min_t_r;
      adv_min_u_s = min_u_r;
      adv_hr_t_s  = hr_t_r;
      adv_hr_u_s  = hr_u_r;
      sec_wrap_s  = 1'b0;
      min_wrap_s  = 1'b0;
      hr_wrap_s   = 1'b0;
      if (sec_u_r >= 4'd9) begin
         adv_sec_u_s = 4'd0;
         if (sec_t_r >= 4'd5) begin
            adv_sec_t_s = 4'd0;
            sec_wrap_s  = 1'b1;
         end else begin
            adv_sec_t_s = sec_t_r + 4'd1;
         end
      end else begin
         adv_sec_u_s = sec_u_r + 4'd1;
      end
      if (sec_wrap_s) begin
         if (min_u_r >= 4'd9) begin
            adv_min_u_s = 4'd0;
            if (min_t_r >= 4'd5) begin
               adv_min_t_s = 4'd0;
               min_wrap_s  = 1'b1;
            end else begin
               adv_min_t_s = min_t_r + 4'd1;
            end
         end else begin
            adv_min_u_s = min_u_r + 4'd1;
         end
      end else begin
         adv_min_u_s = min_u_r;
      end
      if (min_wrap_s) begin
         if ((hr_t_r >= 4'd2) && (hr_u_r >= 4'd3)) begin
            adv_hr_t_s = 4'd0;
            adv_hr_u_s = 4'd0;
            hr_wrap_s  = 1'b1;
         end else if (hr_u_r >= 4'd9) begin
            adv_hr_u_s = 4'd0;
            adv_hr_t_s = hr_t_r + 4'd1;
         end else begin
            adv_hr_u_s = hr_u_r + 4'd1;
         end
      end else begin
         adv_hr_u_s = hr_u_r;
      end
   end

   // Load hour conversion and optional validation
   always_comb begin
      ld_hr_s = bus.load_hr;
      if (bus.mode_12h) begin
         ld_hr_s = bin_to_bcd(load_hour(bcd_to_bin(bus.load_hr[7:4], bus.load_hr[3:0]),
                                        1'b1, bus.load_pm));
      end else begin
         ld_hr_s = bus.load_hr;
      end
`ifdef TOD_LOAD_CHECK_EN
      load_ok_s = load_ok(bus.load_hr, bus.load_min, bus.load_sec, bus.mode_12h);
`else
      load_ok_s = 1'b1;
`endif
   end

   // Time state, prescaler and rollover/error pulses; load outranks advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hr_t_r     <= RST_HR[7:4];
         hr_u_r     <= RST_HR[3:0];
         min_t_r    <= 4'd0;
         min_u_r    <= 4'd0;
         sec_t_r    <= 4'd0;
         sec_u_r    <= 4'd0;
         presc_r    <= 16'd0;
         min_tick_r <= 1'b0;
         hr_tick_r  <= 1'b0;
         day_tick_r <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         min_tick_r <= 1'b0;
         hr_tick_r  <= 1'b0;
         day_tick_r <= 1'b0;
         load_err_r <= 1'b0;
         if (bus.load) begin
            if (load_ok_s) begin
               hr_t_r  <= ld_hr_s[7:4];
               hr_u_r  <= ld_hr_s[3:0];
               min_t_r <= bus.load_min[7:4];
               min_u_r <= bus.load_min[3:0];
               sec_t_r <= bus.load_sec[7:4];
               sec_u_r <= bus.load_sec[3:0];
               presc_r <= 16'd0;
            end else begin
               load_err_r <= 1'b1;
            end
         end else if (bus.run && bus.tick) begin
            if (presc_r == DIV_M1) begin
               presc_r    <= 16'd0;
               hr_t_r     <= adv_hr_t_s;
               hr_u_r     <= adv_hr_u_s;
               min_t_r    <= adv_min_t_s;
               min_u_r    <= adv_min_u_s;
               sec_t_r    <= adv_sec_t_s;
               sec_u_r    <= adv_sec_u_s;
               min_tick_r <= sec_wrap_s;
               hr_tick_r  <= min_wrap_s;
               day_tick_r <= hr_wrap_s;
            end else begin
               presc_r <= presc_r + 16'd1;
            end
         end else begin
            presc_r <= presc_r;
         end
      end
   end

   // Display decode from stored state and current mode
   always_comb begin
      cur_hr_bin_s = bcd_to_bin(hr_t_r, hr_u_r);
   end

   assign bus.hr       = bin_to_bcd(display_hour(cur_hr_bin_s, bus.mode_12h));
   assign bus.min      = {min_t_r, min_u_r};
   assign bus.sec      = {sec_t_r, sec_u_r};
   assign bus.pm       = (cur_hr_bin_s >= 8'd12);
   assign bus.min_tick = min_tick_r;
   assign bus.hr_tick  = hr_tick_r;
   assign bus.day_tick = day_tick_r;
   assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_tod_counter.sv
// Directed bench for tod_counter: one DIV=1 instance and one DIV=4 instance.
module tb_tod_counter;
   logic clk;
   logic rst1;
   logic rst4;
   int   checks;
   int   errors;

   tod_counter_if b1 ();
   tod_counter_if b4 ();

   tod_counter #(.DIV(1), .RST_HR(8'h06)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
   tod_counter #(.DIV(4), .RST_HR(8'h12)) dut4 (.clk(clk), .reset(rst4), .bus(b4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic time1(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      check({tag, "_hr"}, {24'd0, b1.hr}, {24'd0, h});
      check({tag, "_min"}, {24'd0, b1.min}, {24'd0, m});
      check({tag, "_sec"}, {24'd0, b1.sec}, {24'd0, s});
   endtask

   task automatic ticks1(input string tag, input logic mt, input logic ht, input logic dt);
      check({tag, "_min_tick"}, {31'd0, b1.min_tick}, {31'd0, mt});
      check({tag, "_hr_tick"}, {31'd0, b1.hr_tick}, {31'd0, ht});
      check({tag, "_day_tick"}, {31'd0, b1.day_tick}, {31'd0, dt});
   endtask

   task automatic load1(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
      b1.load_hr = h; b1.load_min = m; b1.load_sec = s; b1.load_pm = p;
      b1.load = 1'b1;
      cyc();
      b1.load = 1'b0;
   endtask

   task automatic load4(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      b4.load_hr = h; b4.load_min = m; b4.load_sec = s; b4.load_pm = 1'b0;
      b4.load = 1'b1;
      cyc();
      b4.load = 1'b0;
   endtask

   task automatic tick1;
      b1.tick = 1'b1;
      cyc();
      b1.tick = 1'b0;
   endtask

   task automatic tick4;
      b4.tick = 1'b1;
      cyc();
      b4.tick = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst1 = 1'b0; rst4 = 1'b0;
      b1.tick = 1'b0; b1.run = 1'b0; b1.mode_12h = 1'b0; b1.load = 1'b0;
      b1.load_hr = 8'h00; b1.load_min = 8'h00; b1.load_sec = 8'h00; b1.load_pm = 1'b0;
      b4.tick = 1'b0; b4.run = 1'b0; b4.mode_12h = 1'b0; b4.load = 1'b0;
      b4.load_hr = 8'h00; b4.load_min = 8'h00; b4.load_sec = 8'h00; b4.load_pm = 1'b0;

      // asynchronous reset before any clock edge
      #2;
      rst1 = 1'b1; rst4 = 1'b1;
      #1;
      time1("rst1", 8'h06, 8'h00, 8'h00);
      check("rst1_pm", {31'd0, b1.pm}, 32'd0);
      ticks1("rst1", 1'b0, 1'b0, 1'b0);
      check("rst1_load_err", {31'd0, b1.load_err}, 32'd0);
      check("rst4_hr", {24'd0, b4.hr}, 32'h12);
      check("rst4_pm", {31'd0, b4.pm}, 32'd1);
      check("rst4_presc", {16'd0, dut4.presc_r}, 32'd0);
      cyc();
      cyc();
      rst1 = 1'b0; rst4 = 1'b0;
      b1.run = 1'b1;
      b4.run = 1'b1;

      // day rollover
      load1(8'h23, 8'h59, 8'h58, 1'b0);
      time1("ld235958", 8'h23, 8'h59, 8'h58);
      ticks1("ld235958", 1'b0, 1'b0, 1'b0);
      tick1();
      time1("t235959", 8'h23, 8'h59, 8'h59);
      ticks1("t235959", 1'b0, 1'b0, 1'b0);
      tick1();
      time1("t000000", 8'h00, 8'h00, 8'h00);
      ticks1("t000000", 1'b1, 1'b1, 1'b1);
      cyc();
      ticks1("after_day", 1'b0, 1'b0, 1'b0);
      tick1();
      time1("t000001", 8'h00, 8'h00, 8'h01);
      ticks1("t000001", 1'b0, 1'b0, 1'b0);

      // minute and hour carries through x9 digits
      load1(8'h10, 8'h09, 8'h59, 1'b0);
      tick1();
      time1("t101000", 8'h10, 8'h10, 8'h00);
      ticks1("t101000", 1'b1, 1'b0, 1'b0);
      load1(8'h09, 8'h59, 8'h59, 1'b0);
      tick1();
      time1("t100000", 8'h10, 8'h00, 8'h00);
      ticks1("t100000", 1'b1, 1'b1, 1'b0);

      // 12-hour load and display
      b1.mode_12h = 1'b1;
      load1(8'h12, 8'h05, 8'h00, 1'b0);
      check("am12_hr", {24'd0, b1.hr}, 32'h12);
      check("am12_pm", {31'd0, b1.pm}, 32'd0);
      check("am12_min", {24'd0, b1.min}, 32'h05);
      b1.mode_12h = 1'b0;
      #1;
      check("am12_24h_hr", {24'd0, b1.hr}, 32'h00);
      b1.mode_12h = 1'b1;
      load1(8'h12, 8'h05, 8'h00, 1'b1);
      check("pm12_hr", {24'd0, b1.hr}, 32'h12);
      check("pm12_pm", {31'd0, b1.pm}, 32'd1);
      b1.mode_12h = 1'b0;
      #1;
      check("pm12_24h_hr", {24'd0, b1.hr}, 32'h12);
      b1.mode_12h = 1'b1;
      load1(8'h03, 8'h00, 8'h00, 1'b1);
      check("pm03_hr", {24'd0, b1.hr}, 32'h03);
      b1.mode_12h = 1'b0;
      #1;
      check("pm03_24h_hr", {24'd0, b1.hr}, 32'h15);
      load1(8'h23, 8'h00, 8'h00, 1'b0);
      b1.mode_12h = 1'b1;
      #1;
      check("h23_12h_hr", {24'd0, b1.hr}, 32'h11);
      check("h23_12h_pm", {31'd0, b1.pm}, 32'd1);
      b1.mode_12h = 1'b0;

      // load coincident with a qualifying tick wins
      load1(8'h08, 8'h29, 8'h59, 1'b0);
      b1.tick = 1'b1;
      load1(8'h08, 8'h30, 8'h00, 1'b0);
      b1.tick = 1'b0;
      time1("ldtick", 8'h08, 8'h30, 8'h00);
      ticks1("ldtick", 1'b0, 1'b0, 1'b0);

      // run=0 holds time
      b1.run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick1();
         check("hold_min_tick", {31'd0, b1.min_tick}, 32'd0);
      end
      time1("hold", 8'h08, 8'h30, 8'h00);
      b1.run = 1'b1;

      // illegal loads
      load1(8'h24, 8'h00, 8'h00, 1'b0);
`ifdef TOD_LOAD_CHECK_EN
      check("bad_hr_err", {31'd0, b1.load_err}, 32'd1);
      time1("bad_hr", 8'h08, 8'h30, 8'h00);
      cyc();
      check("bad_hr_err_clr", {31'd0, b1.load_err}, 32'd0);
`else
      check("bad_hr_err_off", {31'd0, b1.load_err}, 32'd0);
`endif
      load1(8'h10, 8'h6A, 8'h00, 1'b0);
`ifdef TOD_LOAD_CHECK_EN
      check("bad_min_err", {31'd0, b1.load_err}, 32'd1);
      time1("bad_min", 8'h08, 8'h30, 8'h00);
      b1.mode_12h = 1'b1;
      load1(8'h00, 8'h10, 8'h00, 1'b0);
      check("bad_12h_err", {31'd0, b1.load_err}, 32'd1);
      b1.mode_12h = 1'b0;
`else
      check("bad_min_err_off", {31'd0, b1.load_err}, 32'd0);
`endif
      load1(8'h08, 8'h30, 8'h00, 1'b0);
      check("good_err", {31'd0, b1.load_err}, 32'd0);
      time1("good", 8'h08, 8'h30, 8'h00);

      // DIV=4 prescaling
      load4(8'h10, 8'h00, 8'h00);
      check("d4_ld_sec", {24'd0, b4.sec}, 32'h00);
      check("d4_ld_presc", {16'd0, dut4.presc_r}, 32'd0);
      for (int i = 1; i <= 7; i++) begin
         tick4();
         check("d4_sec", {24'd0, b4.sec}, (i >= 4) ? 32'h01 : 32'h00);
      end
      check("d4_presc7", {16'd0, dut4.presc_r}, 32'd3);
      tick4();
      check("d4_sec8", {24'd0, b4.sec}, 32'h02);
      check("d4_presc8", {16'd0, dut4.presc_r}, 32'd0);

      // load clears a partial count
      tick4();
      tick4();
      load4(8'h15, 8'h42, 8'h17);
      check("d4_ld_clr_presc", {16'd0, dut4.presc_r}, 32'd0);
      tick4();
      tick4();
      check("d4_mid_presc", {16'd0, dut4.presc_r}, 32'd2);
      check("d4_mid_sec", {24'd0, b4.sec}, 32'h17);
      check("d4_mid_min", {24'd0, b4.min}, 32'h42);

      // asynchronous reset between edges
      #2;
      rst4 = 1'b1;
      #1;
      check("d4_arst_hr", {24'd0, b4.hr}, 32'h12);
      check("d4_arst_min", {24'd0, b4.min}, 32'h00);
      check("d4_arst_sec", {24'd0, b4.sec}, 32'h00);
      check("d4_arst_presc", {16'd0, dut4.presc_r}, 32'd0);
      cyc();
      rst4 = 1'b0;
      tick4();
      check("d4_post_presc", {16'd0, dut4.presc_r}, 32'd1);
      check("d4_post_sec", {24'd0, b4.sec}, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
